// File: rtl/lattice_result_collector.sv
// lattice_result_collector: captures successful lattice results into a hit FIFO,
// hands them to the host over valid/ready and tracks sweep completion.
// Define LATTICE_COLLECT_STATS_EN to add the result/hit statistics counters.
module lattice_result_collector #(
  parameter int LOG2_NUM_CORES = 1,
  parameter int NONCE_WIDTH    = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic                                   res_valid_i,
  input  logic                                   res_success_i,
  input  logic [LOG2_NUM_CORES-1:0]              res_prefix_i,
  input  logic [NONCE_WIDTH-LOG2_NUM_CORES-1:0]  res_nonce_i,
  input  logic                                   res_last_i,
  output logic                                   hit_valid_o,
  input  logic                                   hit_ready_i,
  output logic [NONCE_WIDTH-1:0]                 hit_nonce_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   overflow_o
`ifdef LATTICE_COLLECT_STATS_EN
  ,
  output logic [NONCE_WIDTH:0]                   stat_results_o,
  output logic [15:0]                            stat_hits_o
`endif
);
  localparam int LW = NONCE_WIDTH - LOG2_NUM_CORES;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [LOG2_NUM_CORES-1:0] prefix;
    logic [LW-1:0]             nonce;
  } hit_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  hit_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_busy;
  logic          r_done;
  logic          r_overflow;

  logic w_accept;
  logic w_hit;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // start_i wins over everything: a result arriving with it is discarded.
  assign w_accept = (r_state == S_RUN) & res_valid_i & ~start_i;
  assign w_hit    = w_accept & res_success_i;
  assign w_full   = (r_count == DEPTH_C);
  assign w_pop    = (r_count != '0) & hit_ready_i;
  // When full, a same-cycle pop frees the slot being written.
  assign w_push   = w_hit & (~w_full | w_pop);
  assign w_drop   = w_hit & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (start_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{prefix: res_prefix_i, nonce: res_nonce_i};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (start_i) begin
      r_state    <= S_RUN;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        S_RUN: begin
          if (res_valid_i && res_last_i) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_count == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LATTICE_COLLECT_STATS_EN
  logic [NONCE_WIDTH:0] r_stat_results;
  logic [15:0]          r_stat_hits;

  // Hit count includes hits dropped on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_results <= '0;
      r_stat_hits    <= '0;
    end else if (start_i) begin
      r_stat_results <= '0;
      r_stat_hits    <= '0;
    end else begin
      if (w_accept) r_stat_results <= r_stat_results + (NONCE_WIDTH+1)'(1);
      if (w_hit && r_stat_hits != 16'hFFFF) r_stat_hits <= r_stat_hits + 16'd1;
    end
  end

  assign stat_results_o = r_stat_results;
  assign stat_hits_o    = r_stat_hits;
`endif

  assign hit_valid_o = (r_count != '0);
  assign hit_nonce_o = r_mem[r_rd_ptr];
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_lattice_result_collector.sv
// Randomized scoreboard bench for lattice_result_collector: a sweep-level model
// queues expected hits, a negedge monitor compares whatever the DUT hands out.
module tb_lattice_result_collector;
  localparam int LOG2_NUM_CORES = 1;
  localparam int NONCE_WIDTH    = 32;
  localparam int FIFO_DEPTH     = 4;
  localparam int LW             = NONCE_WIDTH - LOG2_NUM_CORES;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0, res_valid_i = 1'b0, res_success_i = 1'b0, res_last_i = 1'b0;
  logic hit_ready_i = 1'b0;
  logic [LOG2_NUM_CORES-1:0] res_prefix_i = '0;
  logic [LW-1:0]             res_nonce_i  = '0;
  logic hit_valid_o, busy_o, done_o, overflow_o;
  logic [NONCE_WIDTH-1:0] hit_nonce_o;
`ifdef LATTICE_COLLECT_STATS_EN
  logic [NONCE_WIDTH:0] stat_results_o;
  logic [15:0]          stat_hits_o;
`endif

  lattice_result_collector #(
    .LOG2_NUM_CORES(LOG2_NUM_CORES), .NONCE_WIDTH(NONCE_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .res_valid_i(res_valid_i), .res_success_i(res_success_i),
    .res_prefix_i(res_prefix_i), .res_nonce_i(res_nonce_i), .res_last_i(res_last_i),
    .hit_valid_o(hit_valid_o), .hit_ready_i(hit_ready_i), .hit_nonce_o(hit_nonce_o),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
`ifdef LATTICE_COLLECT_STATS_EN
    , .stat_results_o(stat_results_o), .stat_hits_o(stat_hits_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int busy_cnt = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a bounded queue of expected hits plus sweep phase.
  logic [NONCE_WIDTH-1:0] exp_q[$];
  int     m_cnt = 0, m_phase = P_IDLE, m_old = 0, m_hits = 0;
  bit     m_pop, m_ovf = 0, m_done = 0;
  longint m_res = 0;

  always @(posedge clk or posedge rst) begin
    if (rst || start_i) begin
      m_cnt = 0; exp_q.delete(); m_ovf = 0; m_done = 0; m_res = 0; m_hits = 0;
      m_phase = rst ? P_IDLE : P_RUN;
    end else begin
      m_old = m_cnt;
      m_pop = (m_old > 0) && hit_ready_i;
      if (m_phase == P_RUN && res_valid_i) begin
        m_res++;
        if (res_success_i) begin
          if (m_hits < 65535) m_hits++;
          if (m_old < FIFO_DEPTH || m_pop) begin
            exp_q.push_back({res_prefix_i, res_nonce_i});
            m_cnt++;
          end else m_ovf = 1;
        end
        if (res_last_i) m_phase = P_DRAIN;
      end else if (m_phase == P_DRAIN && m_old == 0) begin
        m_phase = P_DONE;
        m_done  = 1;
      end
      if (m_pop) m_cnt--;
    end
  end

  // Monitor: status every cycle, nonce on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("hit_valid", hit_valid_o, m_cnt != 0);
      check("busy", busy_o, m_phase == P_RUN || m_phase == P_DRAIN);
      check("done", done_o, m_done);
      check("overflow", overflow_o, m_ovf);
`ifdef LATTICE_COLLECT_STATS_EN
      check("stat_results", stat_results_o, m_res);
      check("stat_hits", stat_hits_o, m_hits);
`endif
      if (hit_valid_o && hit_ready_i) begin
        check("hit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("hit_nonce", hit_nonce_o, exp_q.pop_front());
      end
      if (busy_o) busy_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic res(bit s, bit l, logic [LW-1:0] n, logic [LOG2_NUM_CORES-1:0] p);
    res_valid_i = 1; res_success_i = s; res_last_i = l; res_nonce_i = n; res_prefix_i = p;
    tick();
    res_valid_i = 0; res_success_i = 0; res_last_i = 0;
  endtask

  task automatic pulse_start();
    start_i = 1; tick(); start_i = 0;
  endtask

  task automatic wait_done(int budget);
    int k = 0;
    while (!done_o && k < budget) begin tick(); k++; end
    check("done_reached", done_o, 1);
  endtask

  function automatic logic [LW-1:0] rnd_nonce();
    return LW'($urandom());
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hit_valid", hit_valid_o, 0);
    check("rst_hit_nonce", hit_nonce_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_overflow", overflow_o, 0);
    @(posedge clk); #1 rst = 0;
    tick();

    // Eight misses ending with last: busy for 8 RUN + 1 DRAIN cycles.
    hit_ready_i = 1;
    busy_cnt = 0;
    pulse_start();
    for (int i = 0; i < 8; i++) res(0, i == 7, rnd_nonce(), LOG2_NUM_CORES'($urandom()));
    wait_done(20);
    check("busy_cycles", busy_cnt, 9);

    // Single hit with one-cycle latency.
    pulse_start();
    res(1, 0, 31'h1234_5678, 1'b1);
    check("single_hit_valid", hit_valid_o, 1);
    check("single_hit_nonce", hit_nonce_o, 32'h9234_5678);
    res(0, 1, rnd_nonce(), 0);
    wait_done(20);

    // Five hits into a 4-deep FIFO with host stalled: fifth dropped.
    pulse_start();
    hit_ready_i = 0;
    for (int i = 0; i < 5; i++) res(1, 0, rnd_nonce(), LOG2_NUM_CORES'($urandom()));
    check("ovf_after_5", overflow_o, 1);
    repeat (3) tick();
    hit_ready_i = 1;
    repeat (6) tick();
    res(0, 1, rnd_nonce(), 0);
    wait_done(20);

    // Full FIFO with simultaneous push and pop: both succeed.
    pulse_start();
    hit_ready_i = 0;
    for (int i = 0; i < 4; i++) res(1, 0, rnd_nonce(), LOG2_NUM_CORES'($urandom()));
    hit_ready_i = 1;
    res(1, 0, rnd_nonce(), 1'b0);
    hit_ready_i = 0;
    check("full_pushpop_valid", hit_valid_o, 1);
    check("full_pushpop_ovf", overflow_o, 0);
    tick();
    hit_ready_i = 1;
    res(0, 1, rnd_nonce(), 0);
    wait_done(20);

    // Last result is a hit while the host stalls: stays in DRAIN.
    pulse_start();
    hit_ready_i = 0;
    res(1, 1, rnd_nonce(), 1'b1);
    repeat (5) tick();
    check("drain_not_done", done_o, 0);
    check("drain_busy", busy_o, 1);
    hit_ready_i = 1;
    wait_done(10);

    // Randomized sweeps, including occasional mid-sweep restarts.
    for (int s = 0; s < 10; s++) begin
      pulse_start();
      for (int c = 0; c < 60; c++) begin
        bit lst;
        lst = (c == 59) || ($urandom_range(0, 24) == 0);
        hit_ready_i   = ($urandom_range(0, 3) != 0);
        res_valid_i   = lst || ($urandom_range(0, 9) < 7);
        res_success_i = ($urandom_range(0, 9) < 5);
        res_last_i    = lst;
        res_nonce_i   = rnd_nonce();
        res_prefix_i  = LOG2_NUM_CORES'($urandom());
        start_i       = !lst && ($urandom_range(0, 49) == 0);
        tick();
        start_i = 0; res_valid_i = 0; res_success_i = 0; res_last_i = 0;
        if (lst) break;
      end
      hit_ready_i = 1;
      wait_done(40);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    // Asynchronous reset with hits buffered mid-sweep.
    pulse_start();
    hit_ready_i = 0;
    for (int i = 0; i < 3; i++) res(1, 0, rnd_nonce(), 1'b1);
    #3 rst = 1;
    #1;
    check("arst_hit_valid", hit_valid_o, 0);
    check("arst_hit_nonce", hit_nonce_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_overflow", overflow_o, 0);
`ifdef LATTICE_COLLECT_STATS_EN
    check("arst_stat_results", stat_results_o, 0);
    check("arst_stat_hits", stat_hits_o, 0);
`endif
    tick();
    rst = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
